// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-side signal bundle for the SAR ADC controller.
// Master drives start/continuous/comp_in; slave (the controller) drives the rest.
interface sar_adc_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             continuous;
  logic             comp_in;
  logic [WIDTH-1:0] dac_code;
  logic             sample_hold;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, continuous, comp_in,
    input  dac_code, sample_hold, busy, done, result
  );

  modport slave (
    input  start, continuous, comp_in,
    output dac_code, sample_hold, busy, done, result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives the external DAC trial code,
// samples the synchronised comparator and resolves one bit per settle window.
module sar_adc_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input logic           clk,
  input logic           rst,
  sar_adc_ctrl_if.slave bus
);
  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ?
                                    SAMPLE_CYCLES : SETTLE_CYCLES + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [WIDTH-1:0]       dac_code_q, dac_code_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   sample_hold_q, sample_hold_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   comp_s;
  logic [WIDTH-1:0]       decided;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.comp_in};
  assign comp_s  = sync_q[SYNC_STAGES-1];
  // Current trial code with bit k kept or cleared by the comparator.
  assign decided = comp_s ? dac_code_q : (dac_code_q & ~(WIDTH'(1) << bit_q));

  // Next state; registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    dac_code_d = dac_code_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        dac_code_d = '0;
        if (bus.start) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end
      end
      S_SAMPLE: begin
        dac_code_d = '0;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d    = S_CONVERT;
          cnt_d      = '0;
          bit_d      = BIT_W'(WIDTH - 1);
          dac_code_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d    = S_DONE;
            dac_code_d = decided;
            result_d   = decided;
          end else begin
            bit_d      = bit_q - BIT_W'(1);
            dac_code_d = decided | (WIDTH'(1) << (bit_q - BIT_W'(1)));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d      = '0;
        dac_code_d = '0;
        state_d    = bus.continuous ? S_SAMPLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sample_hold_d = (state_d == S_SAMPLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      dac_code_q    <= '0;
      result_q      <= '0;
      sample_hold_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sync_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      dac_code_q    <= dac_code_d;
      result_q      <= result_d;
      sample_hold_q <= sample_hold_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sync_q        <= sync_d;
    end
  end

  assign bus.dac_code    = dac_code_q;
  assign bus.sample_hold = sample_hold_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
endmodule
